axi_ddr3_traffic_gen: RTL and testbench

//  Synthesisable AXI4 traffic master and checker for axi_ddr3_lite; generalises the bench's single 128-bit store/fetch.

---
 rtl/axi_ddr3_traffic_gen.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_axi_ddr3_traffic_gen.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ddr3_traffic_gen.sv
// -----------------------------------------------------------------------------
// axi_ddr3_traffic_gen
// AXI4 traffic master and self-checker. Phase 1 writes NUM_TXNS INCR bursts of
// BURST_LEN beats filled from a 32-bit Galois LFSR (taps 32'h80200003, shift
// right, XOR when bit 0 is set). Phase 2 reads every burst back, regenerates
// the same pattern from SEED and counts mismatching / malformed beats.
//
// Ports
//   clock, reset            system clock, synchronous active-high reset
//   start_i                 run request, only looked at while idle
//   busy_o                  high from start acceptance until the done pulse
//   done_o                  one-cycle pulse at the end of a run
//   pass_o                  1 iff the last run finished with zero errors
//   err_count_o             saturating error count of the current/last run
//   err_addr_o              address of the first error seen in the run
//   axi_aw*/axi_w*/axi_b*   AXI4 write address, write data, write response
//   axi_ar*/axi_r*          AXI4 read address, read data
// -----------------------------------------------------------------------------
module axi_ddr3_traffic_gen #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDRS     = 27,
  parameter int unsigned IDS       = 4,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned NUM_TXNS  = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter logic [31:0] SEED      = 32'h0000_0001
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [15:0]        err_count_o,
  output logic [ADDRS-1:0]   err_addr_o,
  // write address channel
  output logic               axi_awvalid_o,
  input  logic               axi_awready_i,
  output logic [ADDRS-1:0]   axi_awaddr_o,
  output logic [IDS-1:0]     axi_awid_o,
  output logic [7:0]         axi_awlen_o,
  output logic [1:0]         axi_awburst_o,
  // write data channel
  output logic               axi_wvalid_o,
  input  logic               axi_wready_i,
  output logic               axi_wlast_o,
  output logic [WIDTH/8-1:0] axi_wstrb_o,
  output logic [WIDTH-1:0]   axi_wdata_o,
  // write response channel
  input  logic               axi_bvalid_i,
  output logic               axi_bready_o,
  input  logic [1:0]         axi_bresp_i,
  input  logic [IDS-1:0]     axi_bid_i,
  // read address channel
  output logic               axi_arvalid_o,
  input  logic               axi_arready_i,
  output logic [ADDRS-1:0]   axi_araddr_o,
  output logic [IDS-1:0]     axi_arid_o,
  output logic [7:0]         axi_arlen_o,
  output logic [1:0]         axi_arburst_o,
  // read data channel
  input  logic               axi_rvalid_i,
  output logic               axi_rready_o,
  input  logic               axi_rlast_i,
  input  logic [1:0]         axi_rresp_i,
  input  logic [IDS-1:0]     axi_rid_i,
  input  logic [WIDTH-1:0]   axi_rdata_i
);

  localparam int unsigned      WORDS       = WIDTH / 32;
  localparam logic [31:0]      TAPS        = 32'h8020_0003;
  localparam logic [ADDRS-1:0] BEAT_BYTES  = ADDRS'(WIDTH / 8);
  localparam logic [ADDRS-1:0] BURST_BYTES = ADDRS'(BURST_LEN * (WIDTH / 8));
  localparam logic [ADDRS-1:0] BASE_A      = ADDRS'(BASE_ADDR);
  localparam logic [8:0]       LAST_BEAT   = 9'(BURST_LEN - 1);
  localparam logic [15:0]      LAST_TXN    = 16'(NUM_TXNS - 1);
  localparam logic [7:0]       AXLEN       = 8'(BURST_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_RSEED, S_AR, S_R, S_DONE
  } state_t;

  // one Galois LFSR step
  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return {1'b0, x[31:1]} ^ (x[0] ? TAPS : 32'h0000_0000);
  endfunction

  // error counter never wraps back to zero
  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'h0001;
  endfunction

  state_t             state_q;
  logic [31:0]        lfsr_q;
  logic [15:0]        txn_q;
  logic [8:0]         beat_q;
  logic [ADDRS-1:0]   addr_q;
  logic               busy_q, done_q, pass_q;
  logic [15:0]        err_count_q;
  logic [ADDRS-1:0]   err_addr_q;
  logic               awvalid_q, wvalid_q, wlast_q, bready_q, arvalid_q, rready_q;
  logic [WIDTH-1:0]   wdata_q;

  logic [WIDTH-1:0]   pat_data_s;
  logic [31:0]        pat_next_d;
  logic [ADDRS-1:0]   beat_addr_s;
  logic               r_err_s;
  logic               b_err_s;

  // Expand the LFSR into one beat of pattern and the state after that beat
  always_comb begin
    logic [31:0] walk;
    walk       = lfsr_q;
    pat_data_s = '0;
    for (int i = 0; i < WORDS; i++) begin
      pat_data_s[32*i +: 32] = walk;
      walk = lfsr_step(walk);
    end
    pat_next_d = walk;
  end

  // Per-beat / per-response error detection and the current beat address
  always_comb begin
    beat_addr_s = addr_q + ADDRS'(beat_q) * BEAT_BYTES;
    r_err_s = (axi_rdata_i != pat_data_s) || (axi_rresp_i != 2'b00) ||
              (axi_rid_i != txn_q[IDS-1:0]) || (axi_rlast_i != (beat_q == LAST_BEAT));
    b_err_s = (axi_bresp_i != 2'b00) || (axi_bid_i != txn_q[IDS-1:0]);
  end

  // Run sequencer: address issue, data beats, response checks, result latch
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED;
      txn_q       <= 16'h0000;
      beat_q      <= 9'h000;
      addr_q      <= BASE_A;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= 16'h0000;
      err_addr_q  <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      wdata_q     <= '0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            err_count_q <= 16'h0000;
            err_addr_q  <= '0;
            pass_q      <= 1'b0;
            lfsr_q      <= SEED;
            txn_q       <= 16'h0000;
            addr_q      <= BASE_A;
            busy_q      <= 1'b1;
            awvalid_q   <= 1'b1;
            state_q     <= S_AW;
          end
        end
        S_AW: begin
          if (axi_awready_i) begin
            // first beat is preloaded so W runs without a bubble
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wdata_q   <= pat_data_s;
            lfsr_q    <= pat_next_d;
            beat_q    <= 9'h000;
            wlast_q   <= (LAST_BEAT == 9'h000);
            state_q   <= S_W;
          end
        end
        S_W: begin
          if (axi_wready_i) begin
            if (beat_q == LAST_BEAT) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= S_B;
            end else begin
              beat_q  <= beat_q + 9'h001;
              wdata_q <= pat_data_s;
              lfsr_q  <= pat_next_d;
              wlast_q <= ((beat_q + 9'h001) == LAST_BEAT);
            end
          end
        end
        S_B: begin
          if (axi_bvalid_i) begin
            bready_q <= 1'b0;
            if (b_err_s) begin
              err_count_q <= sat_inc(err_count_q);
              if (err_count_q == 16'h0000) begin
                err_addr_q <= addr_q;
              end
            end
            txn_q  <= txn_q + 16'h0001;
            addr_q <= addr_q + BURST_BYTES;
            if (txn_q == LAST_TXN) begin
              state_q <= S_RSEED;
            end else begin
              awvalid_q <= 1'b1;
              state_q   <= S_AW;
            end
          end
        end
        S_RSEED: begin
          lfsr_q    <= SEED;
          txn_q     <= 16'h0000;
          addr_q    <= BASE_A;
          arvalid_q <= 1'b1;
          state_q   <= S_AR;
        end
        S_AR: begin
          if (axi_arready_i) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= 9'h000;
            state_q   <= S_R;
          end
        end
        S_R: begin
          if (axi_rvalid_i) begin
            lfsr_q <= pat_next_d;
            if (r_err_s) begin
              err_count_q <= sat_inc(err_count_q);
              if (err_count_q == 16'h0000) begin
                err_addr_q <= beat_addr_s;
              end
            end
            if (beat_q == LAST_BEAT) begin
              rready_q <= 1'b0;
              txn_q    <= txn_q + 16'h0001;
              addr_q   <= addr_q + BURST_BYTES;
              if (txn_q == LAST_TXN) begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                arvalid_q <= 1'b1;
                state_q   <= S_AR;
              end
            end else begin
              beat_q <= beat_q + 9'h001;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          pass_q  <= (err_count_q == 16'h0000);
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign pass_o        = pass_q;
  assign err_count_o   = err_count_q;
  assign err_addr_o    = err_addr_q;
  assign axi_awvalid_o = awvalid_q;
  assign axi_awaddr_o  = addr_q;
  assign axi_awid_o    = txn_q[IDS-1:0];
  assign axi_awlen_o   = AXLEN;
  assign axi_awburst_o = 2'b01;
  assign axi_wvalid_o  = wvalid_q;
  assign axi_wlast_o   = wlast_q;
  assign axi_wstrb_o   = {(WIDTH/8){1'b1}};
  assign axi_wdata_o   = wdata_q;
  assign axi_bready_o  = bready_q;
  assign axi_arvalid_o = arvalid_q;
  assign axi_araddr_o  = addr_q;
  assign axi_arid_o    = txn_q[IDS-1:0];
  assign axi_arlen_o   = AXLEN;
  assign axi_arburst_o = 2'b01;
  assign axi_rready_o  = rready_q;

endmodule

// File: tb/tb_axi_ddr3_traffic_gen.sv
// -----------------------------------------------------------------------------
// Bench for axi_ddr3_traffic_gen: a reactive AXI slave with a word memory,
// optional random ready/valid stalls and injectable faults, plus a reference
// model of the pattern sequence and the expected error results.
// -----------------------------------------------------------------------------
module tb_axi_ddr3_traffic_gen;

  localparam int WIDTH = 32;
  localparam int ADDRS = 27;
  localparam int IDS   = 4;
  localparam int BL    = 4;
  localparam int NT    = 4;
  localparam logic [31:0] SEED = 32'h0000_0001;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic               reset;
  logic               start_i;
  logic               busy_o, done_o, pass_o;
  logic [15:0]        err_count_o;
  logic [ADDRS-1:0]   err_addr_o;
  logic               axi_awvalid_o;
  logic               axi_awready_i = 1'b0;
  logic [ADDRS-1:0]   axi_awaddr_o;
  logic [IDS-1:0]     axi_awid_o;
  logic [7:0]         axi_awlen_o;
  logic [1:0]         axi_awburst_o;
  logic               axi_wvalid_o;
  logic               axi_wready_i = 1'b0;
  logic               axi_wlast_o;
  logic [WIDTH/8-1:0] axi_wstrb_o;
  logic [WIDTH-1:0]   axi_wdata_o;
  logic               axi_bvalid_i = 1'b0;
  logic               axi_bready_o;
  logic [1:0]         axi_bresp_i = 2'b00;
  logic [IDS-1:0]     axi_bid_i = '0;
  logic               axi_arvalid_o;
  logic               axi_arready_i = 1'b0;
  logic [ADDRS-1:0]   axi_araddr_o;
  logic [IDS-1:0]     axi_arid_o;
  logic [7:0]         axi_arlen_o;
  logic [1:0]         axi_arburst_o;
  logic               axi_rvalid_i = 1'b0;
  logic               axi_rready_o;
  logic               axi_rlast_i = 1'b0;
  logic [1:0]         axi_rresp_i = 2'b00;
  logic [IDS-1:0]     axi_rid_i = '0;
  logic [WIDTH-1:0]   axi_rdata_i = '0;

  axi_ddr3_traffic_gen #(
    .WIDTH(WIDTH), .ADDRS(ADDRS), .IDS(IDS), .BURST_LEN(BL),
    .NUM_TXNS(NT), .BASE_ADDR(0), .SEED(SEED)
  ) dut (
    .clock(clock), .reset(reset), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .err_count_o(err_count_o), .err_addr_o(err_addr_o),
    .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
    .axi_awaddr_o(axi_awaddr_o), .axi_awid_o(axi_awid_o),
    .axi_awlen_o(axi_awlen_o), .axi_awburst_o(axi_awburst_o),
    .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
    .axi_wlast_o(axi_wlast_o), .axi_wstrb_o(axi_wstrb_o), .axi_wdata_o(axi_wdata_o),
    .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o),
    .axi_bresp_i(axi_bresp_i), .axi_bid_i(axi_bid_i),
    .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
    .axi_araddr_o(axi_araddr_o), .axi_arid_o(axi_arid_o),
    .axi_arlen_o(axi_arlen_o), .axi_arburst_o(axi_arburst_o),
    .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o),
    .axi_rlast_i(axi_rlast_i), .axi_rresp_i(axi_rresp_i),
    .axi_rid_i(axi_rid_i), .axi_rdata_i(axi_rdata_i)
  );

  // ---------------- slave configuration (set by the stimulus) ----------------
  bit stall_en = 1'b0, fault_b = 1'b0, fault_rlast = 1'b0, corrupt_en = 1'b0;
  int ck = 0, cb = 0, cbit = 0;

  // ---------------- slave observation logs ----------------
  logic [ADDRS-1:0] aw_addr_log[$];
  logic [IDS-1:0]   aw_id_log[$];
  logic [ADDRS-1:0] ar_addr_log[$];
  logic [IDS-1:0]   ar_id_log[$];
  logic [31:0]      w_data_log[$];
  logic             w_last_log[$];
  int               viol = 0;

  logic [31:0] mem [0:63];

  // snapshots of DUT outputs taken at the previous falling edge
  logic             p_awvalid = 1'b0, p_wvalid = 1'b0, p_wlast = 1'b0;
  logic             p_bready = 1'b0, p_arvalid = 1'b0, p_rready = 1'b0;
  logic [ADDRS-1:0] p_awaddr = '0, p_araddr = '0;
  logic [IDS-1:0]   p_awid = '0, p_arid = '0;
  logic [31:0]      p_wdata = '0;

  int wr_base = 0, wr_beat = 0, rd_base = 0, rd_beat = 0;
  logic [IDS-1:0] wr_id = '0, rd_id = '0;
  bit b_pend = 1'b0, rd_act = 1'b0;

  function automatic bit rnd_go();
    return stall_en ? ($urandom_range(99) >= 30) : 1'b1;
  endfunction

  // Slave: works on falling edges; handshakes of the last rising edge are
  // reconstructed from the snapshot of DUT valids/readys and our own drives.
  always @(negedge clock) begin
    bit hs_aw, hs_w, hs_b, hs_ar, hs_r;
    if (reset) begin
      axi_awready_i = 1'b0; axi_wready_i = 1'b0; axi_arready_i = 1'b0;
      axi_bvalid_i = 1'b0; axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0;
      b_pend = 1'b0; rd_act = 1'b0; wr_beat = 0; rd_beat = 0;
    end else begin
      hs_aw = p_awvalid && axi_awready_i;
      hs_w  = p_wvalid  && axi_wready_i;
      hs_b  = axi_bvalid_i && p_bready;
      hs_ar = p_arvalid && axi_arready_i;
      hs_r  = axi_rvalid_i && p_rready;
      // a stalled master must keep valid and payload unchanged
      if (p_awvalid && !hs_aw && (!axi_awvalid_o || axi_awaddr_o !== p_awaddr || axi_awid_o !== p_awid)) viol++;
      if (p_wvalid && !hs_w && (!axi_wvalid_o || axi_wdata_o !== p_wdata || axi_wlast_o !== p_wlast)) viol++;
      if (p_arvalid && !hs_ar && (!axi_arvalid_o || axi_araddr_o !== p_araddr || axi_arid_o !== p_arid)) viol++;
      if (hs_aw) begin
        aw_addr_log.push_back(p_awaddr); aw_id_log.push_back(p_awid);
        wr_base = int'(p_awaddr[7:2]); wr_id = p_awid; wr_beat = 0;
      end
      if (hs_w) begin
        w_data_log.push_back(p_wdata); w_last_log.push_back(p_wlast);
        mem[(wr_base + wr_beat) % 64] = p_wdata;
        wr_beat++;
        if (wr_beat == BL) b_pend = 1'b1;
      end
      if (hs_b) axi_bvalid_i = 1'b0;
      if (hs_ar) begin
        ar_addr_log.push_back(p_araddr); ar_id_log.push_back(p_arid);
        rd_base = int'(p_araddr[7:2]); rd_id = p_arid; rd_beat = 0; rd_act = 1'b1;
      end
      if (hs_r) begin
        rd_beat++;
        if (rd_beat == BL) rd_act = 1'b0;
      end
      axi_awready_i = rnd_go();
      axi_wready_i  = rnd_go();
      axi_arready_i = rnd_go();
      if (b_pend && !axi_bvalid_i) begin
        axi_bvalid_i = 1'b1;
        axi_bid_i    = wr_id;
        axi_bresp_i  = (fault_b && wr_id == '0) ? 2'b10 : 2'b00;
        b_pend       = 1'b0;
      end
      if (!(axi_rvalid_i && !hs_r)) begin
        if (rd_act && rnd_go()) begin
          axi_rvalid_i = 1'b1;
          axi_rid_i    = rd_id;
          axi_rresp_i  = 2'b00;
          axi_rdata_i  = mem[(rd_base + rd_beat) % 64] ^
                         ((corrupt_en && rd_id == IDS'(ck) && rd_beat == cb) ? (32'h1 << cbit) : 32'h0);
          axi_rlast_i  = (fault_rlast && rd_id == 4'd1) ? (rd_beat == BL - 2) : (rd_beat == BL - 1);
        end else begin
          axi_rvalid_i = 1'b0;
        end
      end
    end
    p_awvalid = axi_awvalid_o; p_awaddr = axi_awaddr_o; p_awid = axi_awid_o;
    p_wvalid  = axi_wvalid_o;  p_wdata  = axi_wdata_o;  p_wlast = axi_wlast_o;
    p_bready  = axi_bready_o;
    p_arvalid = axi_arvalid_o; p_araddr = axi_araddr_o; p_arid = axi_arid_o;
    p_rready  = axi_rready_o;
  end

  // ---------------- reference model ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] pat [0:NT*BL-1];

  function automatic logic [31:0] lfsr_ref(input logic [31:0] x);
    return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected error count and first error address for the current fault setup
  task automatic model_errors(output int cnt, output logic [63:0] faddr);
    bit seen;
    bit rl;
    cnt = 0; faddr = 0; seen = 1'b0;
    for (int k = 0; k < NT; k++) begin
      if (fault_b && k == 0) begin
        cnt++;
        if (!seen) begin faddr = 64'(k * BL * 4); seen = 1'b1; end
      end
    end
    for (int k = 0; k < NT; k++) begin
      for (int b = 0; b < BL; b++) begin
        rl = (fault_rlast && k == 1) ? (b == BL - 2) : (b == BL - 1);
        if ((corrupt_en && k == ck && b == cb) || (rl != (b == BL - 1))) begin
          cnt++;
          if (!seen) begin faddr = 64'(k * BL * 4 + b * 4); seen = 1'b1; end
        end
      end
    end
  endtask

  task automatic start_run(input string tag);
    @(posedge clock); #1;
    start_i = 1'b1;
    @(posedge clock); #1;
    start_i = 1'b0;
    check({tag, "_busy_after_start"}, busy_o, 1);
    check({tag, "_pass_cleared"}, pass_o, 0);
    check({tag, "_err_cleared"}, err_count_o, 0);
  endtask

  task automatic finish_run(input string tag);
    int cyc;
    int exp_cnt;
    logic [63:0] exp_addr;
    cyc = 0;
    while (!done_o && cyc < 5000) begin
      @(posedge clock); #1;
      cyc++;
    end
    check({tag, "_done_seen"}, done_o, 1);
    model_errors(exp_cnt, exp_addr);
    check({tag, "_err_count"}, err_count_o, 64'(exp_cnt));
    check({tag, "_err_addr"}, err_addr_o, exp_addr);
    @(posedge clock); #1;
    check({tag, "_done_one_cycle"}, done_o, 0);
    check({tag, "_busy_low"}, busy_o, 0);
    check({tag, "_pass"}, pass_o, (exp_cnt == 0) ? 64'd1 : 64'd0);
  endtask

  task automatic check_traffic(input string tag, input int wb, input int ab, input int rb);
    check({tag, "_w_beats"}, w_data_log.size() - wb, NT * BL);
    check({tag, "_aw_count"}, aw_addr_log.size() - ab, NT);
    check({tag, "_ar_count"}, ar_addr_log.size() - rb, NT);
    for (int i = 0; i < NT * BL && wb + i < w_data_log.size(); i++) begin
      check($sformatf("%s_wdata%0d", tag, i), w_data_log[wb + i], pat[i]);
      check($sformatf("%s_wlast%0d", tag, i), w_last_log[wb + i], (i % BL == BL - 1) ? 64'd1 : 64'd0);
    end
    for (int k = 0; k < NT && ab + k < aw_addr_log.size(); k++) begin
      check($sformatf("%s_awaddr%0d", tag, k), aw_addr_log[ab + k], 64'(k * BL * 4));
      check($sformatf("%s_awid%0d", tag, k), aw_id_log[ab + k], 64'(k));
    end
    for (int k = 0; k < NT && rb + k < ar_addr_log.size(); k++) begin
      check($sformatf("%s_araddr%0d", tag, k), ar_addr_log[rb + k], 64'(k * BL * 4));
      check($sformatf("%s_arid%0d", tag, k), ar_id_log[rb + k], 64'(k));
    end
  endtask

  initial begin
    int wb, ab, rb, cyc, extra;
    reset   = 1'b1;
    start_i = 1'b0;
    pat[0]  = SEED;
    for (int i = 1; i < NT * BL; i++) pat[i] = lfsr_ref(pat[i-1]);

    // reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_awvalid", axi_awvalid_o, 0);
    check("rst_wvalid", axi_wvalid_o, 0);
    check("rst_bready", axi_bready_o, 0);
    check("rst_arvalid", axi_arvalid_o, 0);
    check("rst_rready", axi_rready_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_pass", pass_o, 0);
    check("rst_err_count", err_count_o, 0);
    check("rst_err_addr", err_addr_o, 0);
    check("const_awlen", axi_awlen_o, BL - 1);
    check("const_arlen", axi_arlen_o, BL - 1);
    check("const_awburst", axi_awburst_o, 1);
    check("const_arburst", axi_arburst_o, 1);
    check("const_wstrb", axi_wstrb_o, 4'hF);
    reset = 1'b0;

    // run 1: ideal slave, plus a start pulse while busy that must be ignored
    wb = w_data_log.size(); ab = aw_addr_log.size(); rb = ar_addr_log.size();
    start_run("r1");
    repeat (5) @(posedge clock);
    #1;
    start_i = 1'b1;
    @(posedge clock); #1;
    start_i = 1'b0;
    finish_run("r1");
    check_traffic("r1", wb, ab, rb);
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock); #1;
      if (done_o || busy_o) extra++;
    end
    check("r1_no_restart", extra, 0);

    // run 2: 30% stalls and one random corrupted read bit
    stall_en = 1'b1; corrupt_en = 1'b1;
    ck = $urandom_range(NT - 1); cb = $urandom_range(BL - 1); cbit = $urandom_range(31);
    wb = w_data_log.size(); ab = aw_addr_log.size(); rb = ar_addr_log.size();
    start_run("r2");
    finish_run("r2");
    check_traffic("r2", wb, ab, rb);

    // run 3: write error on txn 0 and early rlast on txn 1
    corrupt_en = 1'b0; fault_b = 1'b1; fault_rlast = 1'b1;
    start_run("r3");
    finish_run("r3");

    // run 4: reset in the read phase, then a clean rerun under stalls
    fault_b = 1'b0; fault_rlast = 1'b0;
    start_run("r4a");
    cyc = 0;
    while (!axi_rready_o && cyc < 3000) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("r4_reached_read", axi_rready_o, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    check("r4_rst_awvalid", axi_awvalid_o, 0);
    check("r4_rst_wvalid", axi_wvalid_o, 0);
    check("r4_rst_arvalid", axi_arvalid_o, 0);
    check("r4_rst_rready", axi_rready_o, 0);
    check("r4_rst_bready", axi_bready_o, 0);
    check("r4_rst_busy", busy_o, 0);
    check("r4_rst_err", err_count_o, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    wb = w_data_log.size(); ab = aw_addr_log.size(); rb = ar_addr_log.size();
    start_run("r4b");
    finish_run("r4b");
    check_traffic("r4b", wb, ab, rb);

    check("stable_payload", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
